// File: rtl/fetch_prefetch_pkg.sv
// fetch_prefetch_pkg: shared fetch definitions.
// Opcodes, exception codes and the prefetch entry bundle.
package fetch_prefetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int FETCH_EXC_W = 4;

    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

    typedef enum logic [FETCH_EXC_W-1:0] {
        EXC_CODE_NO_EXCEPTION   = 4'h0,
        EXC_CODE_INSTR_MISALIGN = 4'h1
    } type_exc_code_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc_next;
        logic                  exc_req;
        type_exc_code_e        exc_code;
    } type_fetch_entry_s;

    // J-type immediate, sign-extended
    function automatic logic [FETCH_XLEN-1:0] jal_imm(
        input logic [FETCH_XLEN-1:0] instr
    );
        return {{12{instr[31]}}, instr[19:12], instr[20],
                instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: registered FIFO of fetch entries.
// Flush empties the queue and overrides push and pop.
module fetch_queue
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  type_fetch_entry_s       wdata_i,
    output type_fetch_entry_s       rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    type_fetch_entry_s mem_q [DEPTH];
    type_fetch_entry_s mem_d [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    // next pointers, count and storage
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // entry storage needs no reset; count guards it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: PC generation with a prefetch queue.
// Redirects flush, JAL is predicted, irqs inject a NOP.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int          XLEN        = FETCH_XLEN,
    parameter int          DEPTH       = 4,
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          JAL_PREDICT = 1,
    parameter int          EXC_W       = FETCH_EXC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [XLEN-1:0]  imem_rdata_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [XLEN-1:0]  id_instr_o,
    output logic [XLEN-1:0]  id_pc_o,
    output logic [XLEN-1:0]  id_pc_next_o,
    output logic             id_exc_req_o,
    output logic [EXC_W-1:0] id_exc_code_o,
    output logic             id_irq_req_o,
    input  logic             csr_redirect_i,
    input  logic [XLEN-1:0]  csr_pc_i,
    input  logic             exe_redirect_i,
    input  logic [XLEN-1:0]  exe_pc_i,
    input  logic             irq_req_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] irq_pc_q, irq_pc_d;
    logic            halt_q, halt_d;
    logic            irq_pend_q, irq_pend_d;
    logic            irq_seen_q, irq_seen_d;

    logic              redirect, misaligned, irq_take;
    logic              push_ack, push_exc, push, pop, flush;
    logic [XLEN-1:0]   tgt, nfpc;
    logic              q_full, q_empty;
    logic [CW-1:0]     q_count;
    type_fetch_entry_s q_wdata, q_head;

    assign redirect   = csr_redirect_i | exe_redirect_i;
    assign tgt        = csr_redirect_i ? csr_pc_i : exe_pc_i;
    assign misaligned = (fpc_q[1:0] != 2'b00);
    assign irq_take   = irq_req_i & ~irq_seen_q & ~redirect
                      & ~irq_pend_q;

    assign imem_req_o  = rst_n & ~redirect & ~halt_q & ~irq_pend_q
                       & ~q_full & ~misaligned;
    assign imem_addr_o = fpc_q;

    assign push_ack = imem_req_o & imem_ack_i & ~irq_take;
    assign push_exc = rst_n & misaligned & ~halt_q & ~q_full
                    & ~redirect & ~irq_take;
    assign push     = push_ack | push_exc;
    assign pop      = ~redirect & ~irq_pend_q & ~q_empty & id_ready_i;
    assign flush    = redirect | irq_take;

    // predicted successor of the word being acked
    always_comb begin
        nfpc = fpc_q + XLEN'(4);
        if ((JAL_PREDICT != 0) && (imem_rdata_i[6:0] == OPCODE_JAL)) begin
            nfpc = fpc_q + jal_imm(imem_rdata_i);
        end
    end

    // entry to push: fetched word or misalignment marker
    always_comb begin
        q_wdata.instr    = imem_rdata_i;
        q_wdata.pc       = fpc_q;
        q_wdata.pc_next  = nfpc;
        q_wdata.exc_req  = 1'b0;
        q_wdata.exc_code = EXC_CODE_NO_EXCEPTION;
        if (push_exc) begin
            q_wdata.instr    = INSTR_NOP;
            q_wdata.pc_next  = fpc_q;
            q_wdata.exc_req  = 1'b1;
            q_wdata.exc_code = EXC_CODE_INSTR_MISALIGN;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // fetch pc, halt and interrupt bookkeeping
    always_comb begin
        fpc_d      = fpc_q;
        halt_d     = halt_q;
        irq_pend_d = irq_pend_q;
        irq_seen_d = irq_seen_q;
        irq_pc_d   = irq_pc_q;
        if (redirect) begin
            fpc_d      = tgt;
            halt_d     = 1'b0;
            irq_pend_d = 1'b0;
        end else if (irq_take) begin
            irq_pend_d = 1'b1;
            irq_seen_d = 1'b1;
            irq_pc_d   = (q_count != '0) ? q_head.pc : fpc_q;
        end else begin
            if (push_ack) fpc_d = nfpc;
            if (push_exc) halt_d = 1'b1;
            if (irq_pend_q && id_ready_i) irq_pend_d = 1'b0;
        end
        if (!irq_req_i) irq_seen_d = 1'b0;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q      <= PC_RESET;
            halt_q     <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_seen_q <= 1'b0;
            irq_pc_q   <= PC_RESET;
        end else begin
            fpc_q      <= fpc_d;
            halt_q     <= halt_d;
            irq_pend_q <= irq_pend_d;
            irq_seen_q <= irq_seen_d;
            irq_pc_q   <= irq_pc_d;
        end
    end

    // ID view: pending irq NOP overrides queue head
    always_comb begin
        id_valid_o    = ~redirect & (irq_pend_q | ~q_empty);
        id_instr_o    = q_head.instr;
        id_pc_o       = q_head.pc;
        id_pc_next_o  = q_head.pc_next;
        id_exc_req_o  = id_valid_o & ~irq_pend_q & q_head.exc_req;
        id_irq_req_o  = ~redirect & irq_pend_q;
        id_exc_code_o = EXC_CODE_NO_EXCEPTION;
        if (irq_pend_q) begin
            id_instr_o   = INSTR_NOP;
            id_pc_o      = irq_pc_q;
            id_pc_next_o = irq_pc_q;
        end
        if (id_exc_req_o) id_exc_code_o = q_head.exc_code;
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: two DUTs (JAL_PREDICT 0 and 1) on shared
// stimulus, each checked every cycle against a queue-level model.
module tb_fetch_prefetch;
    import fetch_prefetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ack, rdy, csr, exe, irq;
    logic [31:0] rdata, csr_pc, exe_pc;

    logic        n_ack, n_rdy, n_csr, n_exe, n_irq;
    logic [31:0] n_rd, n_cpc, n_epc;

    logic        o_req [2];
    logic [31:0] o_addr [2];
    logic        o_valid [2];
    logic [31:0] o_instr [2];
    logic [31:0] o_pc [2];
    logic [31:0] o_next [2];
    logic        o_exc [2];
    logic [3:0]  o_code [2];
    logic        o_irq [2];

    fetch_prefetch #(.JAL_PREDICT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(o_req[0]), .imem_addr_o(o_addr[0]),
        .imem_ack_i(ack), .imem_rdata_i(rdata),
        .id_valid_o(o_valid[0]), .id_ready_i(rdy),
        .id_instr_o(o_instr[0]), .id_pc_o(o_pc[0]),
        .id_pc_next_o(o_next[0]), .id_exc_req_o(o_exc[0]),
        .id_exc_code_o(o_code[0]), .id_irq_req_o(o_irq[0]),
        .csr_redirect_i(csr), .csr_pc_i(csr_pc),
        .exe_redirect_i(exe), .exe_pc_i(exe_pc),
        .irq_req_i(irq)
    );

    fetch_prefetch #(.JAL_PREDICT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(o_req[1]), .imem_addr_o(o_addr[1]),
        .imem_ack_i(ack), .imem_rdata_i(rdata),
        .id_valid_o(o_valid[1]), .id_ready_i(rdy),
        .id_instr_o(o_instr[1]), .id_pc_o(o_pc[1]),
        .id_pc_next_o(o_next[1]), .id_exc_req_o(o_exc[1]),
        .id_exc_code_o(o_code[1]), .id_irq_req_o(o_irq[1]),
        .csr_redirect_i(csr), .csr_pc_i(csr_pc),
        .exe_redirect_i(exe), .exe_pc_i(exe_pc),
        .irq_req_i(irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // reference model: a plain list of entries per instance
    logic [31:0] m_fpc [2];
    logic [31:0] m_ipc [2];
    logic        m_halt [2];
    logic        m_pend [2];
    logic        m_seen [2];
    int          m_cnt [2];
    logic [31:0] m_ins [2][8];
    logic [31:0] m_pc [2][8];
    logic [31:0] m_nx [2][8];
    logic        m_ex [2][8];

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        logic signed [31:0] v;
        v = 0;
        v[20]    = w[31];
        v[19:12] = w[19:12];
        v[11]    = w[20];
        v[10:1]  = w[30:21];
        if (w[31]) v = v - 32'sh0020_0000;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_fpc[k] = 32'h0; m_ipc[k] = 32'h0;
            m_halt[k] = 0; m_pend[k] = 0; m_seen[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_cycle(input int k);
        logic redir, full, mis, req, take, valid, eexc, eirq;
        logic [31:0] tgt, nf;
        string p;
        p     = $sformatf("j%0d.", k);
        redir = csr | exe;
        tgt   = csr ? csr_pc : exe_pc;
        full  = (m_cnt[k] == 4);
        mis   = (m_fpc[k] % 4) != 0;
        req   = !redir && !m_halt[k] && !m_pend[k] && !full && !mis;
        take  = irq && !m_seen[k] && !redir && !m_pend[k];
        valid = !redir && (m_pend[k] || m_cnt[k] > 0);
        eirq  = valid && m_pend[k];
        eexc  = valid && !m_pend[k] && m_ex[k][0];
        chk({p, "req"}, o_req[k], req);
        chk({p, "addr"}, o_addr[k], m_fpc[k]);
        chk({p, "valid"}, o_valid[k], valid);
        chk({p, "exc"}, o_exc[k], eexc);
        chk({p, "irq"}, o_irq[k], eirq);
        if (valid && m_pend[k]) begin
            chk({p, "instr"}, o_instr[k], INSTR_NOP);
            chk({p, "pc"}, o_pc[k], m_ipc[k]);
            chk({p, "pcnext"}, o_next[k], m_ipc[k]);
        end else if (valid) begin
            chk({p, "instr"}, o_instr[k], m_ins[k][0]);
            chk({p, "pc"}, o_pc[k], m_pc[k][0]);
            chk({p, "pcnext"}, o_next[k], m_nx[k][0]);
            chk({p, "code"}, o_code[k], eexc ?
                32'(EXC_CODE_INSTR_MISALIGN) :
                32'(EXC_CODE_NO_EXCEPTION));
        end
        if (redir) begin
            m_cnt[k] = 0; m_fpc[k] = tgt;
            m_halt[k] = 0; m_pend[k] = 0;
        end else if (take) begin
            m_ipc[k] = (m_cnt[k] > 0) ? m_pc[k][0] : m_fpc[k];
            m_cnt[k] = 0; m_pend[k] = 1; m_seen[k] = 1;
        end else begin
            if (m_pend[k] && rdy) begin
                m_pend[k] = 0;
            end else if (!m_pend[k] && m_cnt[k] > 0 && rdy) begin
                for (int i = 0; i < 7; i++) begin
                    m_ins[k][i] = m_ins[k][i+1];
                    m_pc[k][i]  = m_pc[k][i+1];
                    m_nx[k][i]  = m_nx[k][i+1];
                    m_ex[k][i]  = m_ex[k][i+1];
                end
                m_cnt[k]--;
            end
            if (req && ack) begin
                nf = m_fpc[k] + 4;
                if (k == 1 && rdata[6:0] == 7'b1101111)
                    nf = m_fpc[k] + imm_j(rdata);
                m_ins[k][m_cnt[k]] = rdata;
                m_pc[k][m_cnt[k]]  = m_fpc[k];
                m_nx[k][m_cnt[k]]  = nf;
                m_ex[k][m_cnt[k]]  = 0;
                m_cnt[k]++;
                m_fpc[k] = nf;
            end else if (mis && !m_halt[k] && !full) begin
                m_ins[k][m_cnt[k]] = INSTR_NOP;
                m_pc[k][m_cnt[k]]  = m_fpc[k];
                m_nx[k][m_cnt[k]]  = m_fpc[k];
                m_ex[k][m_cnt[k]]  = 1;
                m_cnt[k]++;
                m_halt[k] = 1;
            end
        end
        if (!irq) m_seen[k] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ack = n_ack; rdata = n_rd; rdy = n_rdy;
        csr = n_csr; csr_pc = n_cpc;
        exe = n_exe; exe_pc = n_epc; irq = n_irq;
        #3;
        for (int k = 0; k < 2; k++) model_cycle(k);
    endtask

    task automatic go(input logic a, input logic [31:0] rd,
                      input logic r);
        n_ack = a; n_rd = rd; n_rdy = r; n_csr = 0; n_exe = 0;
        tick();
    endtask

    task automatic redir_exe(input logic [31:0] pc);
        n_exe = 1; n_epc = pc; n_csr = 0; n_ack = 1; n_rdy = 1;
        tick();
        n_exe = 0;
    endtask

    int nreq;

    initial begin
        rst_n = 0;
        ack = 0; rdy = 0; csr = 0; exe = 0; irq = 0;
        rdata = 0; csr_pc = 0; exe_pc = 0;
        n_ack = 0; n_rdy = 0; n_csr = 0; n_exe = 0; n_irq = 0;
        n_rd = INSTR_NOP; n_cpc = 0; n_epc = 0;
        repeat (2) @(posedge clk);
        #4;
        for (int k = 0; k < 2; k++) begin
            chk("rst.req", o_req[k], 0);
            chk("rst.addr", o_addr[k], 32'h0);
            chk("rst.valid", o_valid[k], 0);
            chk("rst.exc", o_exc[k], 0);
            chk("rst.irq", o_irq[k], 0);
            chk("rst.code", o_code[k], 32'(EXC_CODE_NO_EXCEPTION));
        end
        model_reset();
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            go(1, INSTR_NOP, 1);
            chk("strm.addr", o_addr[1], 32'(4 * i));
            if (i > 0) begin
                chk("strm.valid", o_valid[1], 1);
                chk("strm.pc", o_pc[1], 32'(4 * (i - 1)));
            end
        end

        redir_exe(32'h0);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            go(1, INSTR_NOP, 0);
            nreq += int'(o_req[1]);
        end
        chk("fill.reqs", nreq, 4);
        chk("fill.req", o_req[1], 0);
        chk("fill.addr", o_addr[1], 32'h10);
        for (int i = 0; i < 4; i++) begin
            go(0, INSTR_NOP, 1);
            chk("drain.pc", o_pc[1], 32'(4 * i));
        end
        go(0, INSTR_NOP, 1);
        chk("drain.valid", o_valid[1], 0);
        chk("drain.addr", o_addr[1], 32'h10);

        redir_exe(32'h20);
        go(1, 32'h0080006F, 0);
        go(0, INSTR_NOP, 0);
        chk("jal1.addr", o_addr[1], 32'h28);
        chk("jal1.next", o_next[1], 32'h28);
        chk("jal0.addr", o_addr[0], 32'h24);
        chk("jal0.next", o_next[0], 32'h24);

        redir_exe(32'h0);
        repeat (3) go(1, INSTR_NOP, 0);
        n_exe = 1; n_epc = 32'h100; n_ack = 1; n_rdy = 1;
        tick();
        chk("flush.valid", o_valid[1], 0);
        chk("flush.req", o_req[1], 0);
        go(0, INSTR_NOP, 0);
        chk("flush.addr", o_addr[1], 32'h100);
        chk("flush.empty", o_valid[1], 0);

        n_csr = 1; n_cpc = 32'h200; n_exe = 1; n_epc = 32'h300;
        n_ack = 0;
        tick();
        go(0, INSTR_NOP, 0);
        chk("prio.addr", o_addr[1], 32'h200);
        redir_exe(32'h302);
        go(1, INSTR_NOP, 0);
        chk("mis.req", o_req[1], 0);
        go(1, INSTR_NOP, 0);
        chk("mis.valid", o_valid[1], 1);
        chk("mis.exc", o_exc[1], 1);
        chk("mis.pc", o_pc[1], 32'h302);
        chk("mis.code", o_code[1], 32'(EXC_CODE_INSTR_MISALIGN));
        go(1, INSTR_NOP, 1);
        go(1, INSTR_NOP, 1);
        chk("halt.valid", o_valid[1], 0);
        chk("halt.req", o_req[1], 0);

        redir_exe(32'h40);
        go(1, INSTR_NOP, 0);
        go(1, INSTR_NOP, 0);
        n_irq = 1;
        go(1, INSTR_NOP, 0);
        go(1, INSTR_NOP, 1);
        chk("irq.flag", o_irq[1], 1);
        chk("irq.pc", o_pc[1], 32'h40);
        chk("irq.instr", o_instr[1], INSTR_NOP);
        for (int i = 0; i < 3; i++) begin
            go(1, INSTR_NOP, 1);
            chk("irq.once", o_irq[1], 0);
        end
        n_irq = 0;
        go(1, INSTR_NOP, 1);
        n_irq = 1;
        go(1, INSTR_NOP, 0);
        go(1, INSTR_NOP, 0);
        chk("irq.again", o_irq[1], 1);
        n_irq = 0;
        go(0, INSTR_NOP, 1);

        for (int i = 0; i < 3000; i++) begin
            n_csr = ($urandom % 40) == 0;
            n_exe = ($urandom % 20) == 0;
            n_cpc = {22'h0, 8'($urandom), 2'b00};
            n_epc = {22'h0, 8'($urandom), 2'b00};
            if (($urandom % 10) == 0) n_epc[1:0] = 2'($urandom);
            if (($urandom % 30) == 0) n_irq = ~n_irq;
            n_ack = ($urandom % 10) < 6;
            n_rdy = ($urandom % 10) < 6;
            n_rd  = $urandom;
            if (($urandom % 4) == 0) n_rd[6:0] = OPCODE_JAL;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor to the single-entry fetch stage: PC generation plus a DEPTH-entry prefetch queue, so IMEM requests continue while ID back-pressures.
- Sits between IMEM (req/ack) and ID (valid/ready).
- Applies CSR/EXE redirects with queue flush; optional static JAL prediction; misaligned-PC exception; interrupt injection as a marked NOP.

Parameters:
- XLEN, 32, datapath/PC width
- DEPTH, 4, prefetch queue entries (power of 2, >=2)
- PC_RESET, 32'h0000_0000, PC after reset
- JAL_PREDICT, 1, 1: redirect fetch to JAL target at fetch time; 0: always PC+4
- EXC_W, 4, exception-code width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address (= fpc)
- imem_ack_i  in  1  response valid this cycle (only honoured while imem_req_o=1)
- imem_rdata_i  in  XLEN  instruction word, valid with ack
- id_valid_o  out  1  queue head valid to ID
- id_ready_i  in  1  ID accepts head
- id_instr_o  out  XLEN  instruction
- id_pc_o  out  XLEN  instruction PC
- id_pc_next_o  out  XLEN  address fetched after this instruction (prediction)
- id_exc_req_o  out  1  fetch exception on this entry
- id_exc_code_o  out  EXC_W  exception code
- id_irq_req_o  out  1  entry is an interrupt-injection NOP
- csr_redirect_i  in  1  CSR new-PC request (trap/mret/wfi)
- csr_pc_i  in  XLEN  CSR target
- exe_redirect_i  in  1  EXE new-PC request (branch/jalr/mispredict)
- exe_pc_i  in  XLEN  EXE target
- irq_req_i  in  1  interrupt pending (level)

Behaviour:
- rst_n is a synchronous, active-low reset; clk is the clock.
- Reset values: fpc=PC_RESET, queue empty, halt=0, irq_pend=0, irq_seen=0.
  - Outputs at reset: imem_req_o=0 on the reset cycle, imem_addr_o=PC_RESET, id_valid_o=0, id_exc_req_o=0, id_irq_req_o=0, id_exc_code_o=EXC_CODE_NO_EXCEPTION.
- Request issue:
  - imem_req_o = ~redirect & ~halt & ~irq_pend & (count<DEPTH) & ~misaligned, where misaligned = fpc[1:0]!=0.
  - The address is held stable until ack, redirect or irq. Deasserting req abandons the request; IMEM must tolerate this.
- Push on ack (req & ack & ~redirect & ~irq_take):
  - Entry pushed as {rdata, fpc, nfpc, exc=0}.
  - nfpc = fpc+jal_imm if JAL_PREDICT and rdata[6:0]==OPCODE_JAL, else fpc+4.
  - fpc <= nfpc.
  - jal_imm = sign-extended {rdata[31], rdata[19:12], rdata[20], rdata[30:21], 0}. Additions wrap mod 2^XLEN.
- Latency: ack in cycle t -> id_valid_o=1 in t+1 (registered queue, no bypass). Back-to-back acks sustain 1 instr/cycle.
- Pop: id_valid_o & id_ready_i. Simultaneous push and pop leaves count unchanged. Push never occurs at count==DEPTH because req is gated.
- Misaligned PC:
  - When fpc misaligned, not halted and count<DEPTH, push {INSTR_NOP, fpc, fpc, exc=1, code=EXC_CODE_INSTR_MISALIGN} without an IMEM request.
  - Set halt=1; no further fetch until a redirect.
- Redirect (csr_redirect_i | exe_redirect_i):
  - CSR has priority over EXE.
  - In that cycle: imem_req_o=0, id_valid_o=0, any ack ignored.
  - Next state: queue flushed (count=0), fpc <= selected target, halt=0, irq_pend=0.
  - Redirect beats push, pop and irq in the same cycle.
- Interrupt:
  - irq_take = irq_req_i & ~irq_seen & ~redirect & ~irq_pend.
  - On take: queue flushed, irq_pc <= head pc if non-empty else fpc, irq_pend=1, irq_seen=1.
  - While irq_pend, the ID outputs are {INSTR_NOP, irq_pc, irq_pc, exc=0, irq=1} with id_valid_o=1. This takes priority over the queue.
  - irq_pend clears when ID accepts or on redirect; fpc is unchanged.
  - irq_seen clears when irq_req_i=0, so a held level injects once.
- When id_valid_o=0, the ID data outputs are don't-care, but id_exc_req_o and id_irq_req_o must be 0.

Decomposition:
- Shared defs header (with existing mem/pipeline defines):
  - OPCODE_JAL (7'b1101111), INSTR_NOP (32'h0000_0013)
  - type_exc_code_e with EXC_CODE_NO_EXCEPTION and EXC_CODE_INSTR_MISALIGN
  - entry struct type_fetch_entry_s {instr, pc, pc_next, exc_req, exc_code}
- Sub-module fetch_queue: synchronous FIFO of type_fetch_entry_s.
  - DEPTH parameter.
  - push/pop/flush ports plus count, full and empty outputs.
  - Flush dominates push/pop.
  - Pointers wrap modulo DEPTH; count has width $clog2(DEPTH)+1.

Test Plan:
- Reset, IMEM acks every cycle, rdata=NOPs, id_ready_i=1 -> addrs 0x0,0x4,0x8...; id_pc_o=0x0 one cycle after first ack; 1 instr/cycle.
- id_ready_i=0, DEPTH=4, continuous ack -> exactly 4 pushes, then imem_req_o=0. id_ready_i=1 -> pops in order with pc 0x0..0xC, fetch resumes at 0x10.
- rdata=32'h0080006F (jal +8) at pc 0x20, JAL_PREDICT=1 -> next addr 0x28 and entry pc_next=0x28. With JAL_PREDICT=0 -> next addr 0x24.
- Queue holding 3 entries, exe_redirect_i=1 with exe_pc_i=0x100, ack in same cycle -> id_valid_o=0 that cycle, ack dropped, next req addr 0x100, queue empty.
- csr_redirect_i (0x200) and exe_redirect_i (0x300) together -> fetch 0x200. Then exe_pc_i=0x302 -> exception entry pc=0x302, code INSTR_MISALIGN, no IMEM req, halt until next redirect.
- irq_req_i held high with head pc 0x40 -> single NOP with id_irq_req_o=1, pc 0x40, queue flushed. No second injection until irq_req_i falls and rises again.
